// File: rtl/cmos_cells_pkg.sv
// Shared definitions for the CMOS cell-set scan register bank:
// the scan state encoding and the segment-width helper.
package cmos_cells_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } scan_state_t;

  function automatic int seg_width(input int width, input int chains);
    return width / chains;
  endfunction

  // Segment width of the default 8-bit, single-chain build.
  localparam int SEG = seg_width(8, 1);

endpackage

// File: rtl/cmos_scan_seg.sv
// One scan-chain segment: parallel load, synchronous clear and a
// shift toward the MSB, with the MSB brought out as the scan output.
module cmos_scan_seg #(
  parameter int SEG = 8,
  parameter logic [SEG-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           clr,
  input  logic           shift,
  input  logic [SEG-1:0] d,
  input  logic           si,
  output logic [SEG-1:0] q,
  output logic           so
);

  // Appending si below q gives the shifted value and the outgoing MSB in one
  // vector, which also holds for a one-bit segment.
  logic [SEG:0] ext;
  assign ext = {q, si};
  assign so  = ext[SEG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (shift) begin
      q <= ext[SEG-1:0];
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cmos_scan_reg_bank.sv
// Register bank with parallel load, synchronous clear and counted scan shift
// over CHAINS independent segments; busy/done decoded from the scan FSM.
module cmos_scan_reg_bank
  import cmos_cells_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHAINS = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  d,
  input  logic              sclr,
  input  logic              scan_start,
  input  logic [CNT_W-1:0]  scan_len,
  input  logic [CHAINS-1:0] si,
  output logic [CHAINS-1:0] so,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              done
);

  localparam int SEG_W = seg_width(WIDTH, CHAINS);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (scan_start) begin
            if (scan_len != '0) begin
              cnt   <= scan_len;
              state <= ST_SHIFT;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  // A scan request in IDLE takes the cycle, so load and clear stand down.
  logic idle_free;
  logic do_shift;
  logic do_clr;
  logic do_load;

  assign idle_free = (state == ST_IDLE) && !scan_start;
  assign do_shift  = (state == ST_SHIFT);
  assign do_clr    = idle_free && sclr;
  assign do_load   = idle_free && en;

  for (genvar c = 0; c < CHAINS; c++) begin : g_seg
    cmos_scan_seg #(
      .SEG       (SEG_W),
      .RESET_VAL (RESET_VAL[c*SEG_W +: SEG_W])
    ) u_seg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (do_load),
      .clr   (do_clr),
      .shift (do_shift),
      .d     (d[c*SEG_W +: SEG_W]),
      .si    (si[c]),
      .q     (q[c*SEG_W +: SEG_W]),
      .so    (so[c])
    );
  end

endmodule

// File: tb/tb_cmos_scan_reg_bank.sv
// Directed bench for cmos_scan_reg_bank: one single-chain and one two-chain
// instance, both 8 bits wide with reset value 8'hA5.
module tb_cmos_scan_reg_bank;

  logic clk;
  logic rst_n;

  logic       en1, sclr1, ss1;
  logic [7:0] d1;
  logic [3:0] len1;
  logic [0:0] si1, so1;
  logic [7:0] q1;
  logic       busy1, done1;

  logic       en2, sclr2, ss2;
  logic [7:0] d2;
  logic [3:0] len2;
  logic [1:0] si2, so2;
  logic [7:0] q2;
  logic       busy2, done2;

  int total = 0;
  int bad   = 0;

  cmos_scan_reg_bank #(.WIDTH(8), .CHAINS(1), .RESET_VAL(8'hA5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .d(d1), .sclr(sclr1),
    .scan_start(ss1), .scan_len(len1), .si(si1), .so(so1),
    .q(q1), .busy(busy1), .done(done1)
  );

  cmos_scan_reg_bank #(.WIDTH(8), .CHAINS(2), .RESET_VAL(8'hA5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .d(d2), .sclr(sclr2),
    .scan_start(ss2), .scan_len(len2), .si(si2), .so(so2),
    .q(q2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pat3[3];
    int so3[3];
    int nb;
    int nd;
    pat3 = '{1, 0, 1};
    so3  = '{1, 0, 0};

    rst_n = 1'b1;
    en1 = 0; sclr1 = 0; ss1 = 0; d1 = '0; len1 = '0; si1 = '0;
    en2 = 0; sclr2 = 0; ss2 = 0; d2 = '0; len2 = '0; si2 = '0;

    // Asynchronous reset asserted between clock edges
    #12 rst_n = 1'b0;
    #1;
    chk("rst_q1", q1, 8'hA5);
    chk("rst_q2", q2, 8'hA5);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", q1, 8'hA5);
    end

    // sclr outranks en, then plain load
    @(negedge clk); en1 = 1; d1 = 8'h3C; sclr1 = 1;
    step();
    chk("sclr_pri", q1, 8'h00);
    @(negedge clk); sclr1 = 0;
    step();
    chk("load", q1, 8'h3C);

    // Single chain: 0x81, three shifts of 1,0,1
    @(negedge clk); d1 = 8'h81;
    step();
    chk("load81", q1, 8'h81);
    @(negedge clk); en1 = 0; ss1 = 1; len1 = 4'd3; si1 = 1'b0;
    step();
    chk("start_hold", q1, 8'h81);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ss1 = 0; si1 = pat3[i][0:0];
      chk("sh_busy", busy1, 1);
      chk("sh_so", so1, so3[i]);
      step();
    end
    chk("sh_end_busy", busy1, 0);
    chk("sh_end_done", done1, 1);
    chk("sh_end_q", q1, 8'h0D);
    step();
    chk("sh_idle_done", done1, 0);
    chk("sh_idle_busy", busy1, 0);

    // Two chains: 0xF0, four shifts of 2'b01, en/sclr ignored mid-shift
    @(negedge clk); en2 = 1; d2 = 8'hF0;
    step();
    chk("load_f0", q2, 8'hF0);
    @(negedge clk); en2 = 0; ss2 = 1; len2 = 4'd4; si2 = 2'b01;
    step();
    chk("c2_busy", busy2, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); ss2 = 0; en2 = (i == 2); d2 = 8'hFF; sclr2 = (i == 3);
      step();
    end
    chk("c2_done", done2, 1);
    chk("c2_q", q2, 8'h0F);
    @(negedge clk); en2 = 0; sclr2 = 0;
    step();
    chk("c2_done_off", done2, 0);
    chk("c2_q_hold", q2, 8'h0F);

    // Zero-length scan
    @(negedge clk); ss1 = 1; len1 = 4'd0;
    step();
    chk("z_busy", busy1, 0);
    chk("z_done", done1, 1);
    chk("z_q", q1, 8'h0D);
    @(negedge clk); ss1 = 0;
    step();
    chk("z_done_off", done1, 0);

    // Reset during the second of five shifts
    @(negedge clk); ss1 = 1; len1 = 4'd5; si1 = 1'b0;
    step();
    @(negedge clk); ss1 = 0;
    step();
    @(negedge clk);
    chk("mid_busy", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q", q1, 8'hA5);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_done", done1, 0);
    chk("post_rst_busy", busy1, 0);
    step();
    chk("post_rst_done2", done1, 0);

    // Fresh five-shift scan from the reset value
    @(negedge clk); ss1 = 1; len1 = 4'd5;
    step();
    @(negedge clk); ss1 = 0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy1) nb++;
      if (done1) nd++;
      step();
    end
    chk("fresh_busy_cnt", nb, 5);
    chk("fresh_done_cnt", nd, 1);
    chk("fresh_q", q1, 8'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
